// File: rtl/stream_tieoff_pkg.sv
// Shared types and constants for the stream tie-off source.
package stream_tieoff_pkg;

  // Encoding 2'd3 is reserved and behaves like PAT_CONST.
  typedef enum logic [1:0] {
    PAT_CONST = 2'd0,
    PAT_COUNT = 2'd1,
    PAT_LFSR  = 2'd2
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/stream_pattern_gen.sv
// Registered data-word generator: constant, counting or Galois LFSR sequence.
module stream_pattern_gen
  import stream_tieoff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [DATA_WIDTH-1:0] Taps = DATA_WIDTH'(LFSR_TAPS);

  pattern_e              mode_q, mode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    mode_d = mode_q;
    data_d = data_q;
    if (load_i) begin
      mode_d = pattern_e'(mode_i);
      data_d = seed_i;
      // An all-zero LFSR state would never leave zero.
      if (pattern_e'(mode_i) == PAT_LFSR && seed_i == '0) begin
        data_d = DATA_WIDTH'(1);
      end
    end else if (advance_i) begin
      case (mode_q)
        PAT_COUNT: data_d = data_q + DATA_WIDTH'(1);
        PAT_LFSR:  data_d = (data_q >> 1) ^ (data_q[0] ? Taps : '0);
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= PAT_CONST;
      data_q <= '0;
    end else begin
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/stream_tieoff_source.sv
// Programmable valid/ready traffic source for otherwise unconnected stream inputs.
module stream_tieoff_source
  import stream_tieoff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter logic [31:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [LEN_WIDTH-1:0]  burst_len_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic [LEN_WIDTH-1:0]  beats_o
);

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [LEN_WIDTH-1:0]   beats_q, beats_d;
  logic                   bounded_q, bounded_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   handshake;
  logic                   burst_end;
  logic                   gen_load;
  logic                   gen_advance;

  assign valid_o   = (state_q == RUN);
  assign busy_o    = (state_q == RUN);
  assign beats_o   = beats_q;
  assign handshake = valid_o & ready_i;
  assign last_o    = valid_o & bounded_q & (rem_q == LEN_WIDTH'(1));
  // A stop seen in the same cycle as a handshake ends the burst on that beat.
  assign burst_end = handshake & (last_o | stop_pend_q | stop_i);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    bounded_d   = bounded_q;
    stop_pend_d = stop_pend_q;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = RUN;
          rem_d       = burst_len_i;
          bounded_d   = (burst_len_i != '0);
          beats_d     = '0;
          stop_pend_d = 1'b0;
          gen_load    = 1'b1;
        end
      end
      RUN: begin
        if (stop_i) begin
          stop_pend_d = 1'b1;
        end
        if (handshake) begin
          beats_d     = beats_q + LEN_WIDTH'(1);
          gen_advance = 1'b1;
          if (bounded_q) begin
            rem_d = rem_q - LEN_WIDTH'(1);
          end
        end
        if (burst_end) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      beats_q     <= '0;
      bounded_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      bounded_q   <= bounded_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  stream_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_TAPS  (LFSR_TAPS)
  ) u_pattern_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (gen_load),
    .advance_i (gen_advance),
    .mode_i    (mode_i),
    .seed_i    (seed_i),
    .data_o    (data_o)
  );

endmodule

// File: tb/tb_stream_tieoff_source.sv
// Self-checking bench: beat-level reference model plus directed bursts with literal checks.
module tb_stream_tieoff_source;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic [DW-1:0] seed_i = '0;
  logic [LW-1:0] burst_len_i = '0;
  logic          ready_i = 1'b0;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          busy_o;
  logic [LW-1:0] beats_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_tieoff_source #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .LFSR_TAPS  (TAPS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mode_i      (mode_i),
    .seed_i      (seed_i),
    .burst_len_i (burst_len_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .beats_o     (beats_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data word carried by beat k of a burst, from the pattern definitions.
  function automatic logic [DW-1:0] data_at(input int unsigned mode, input logic [DW-1:0] seed,
                                            input int unsigned k);
    logic [DW-1:0] d;
    case (mode)
      1: d = seed + DW'(k);
      2: begin
        d = seed;
        for (int i = 0; i < int'(k); i++) d = (d >> 1) ^ (d[0] ? TAPS : 32'h0);
      end
      default: d = seed;
    endcase
    return d;
  endfunction

  // Reference model: burst-level state, updated from the inputs each clock.
  bit          m_init = 0;
  bit          m_busy = 0;
  bit          m_zero = 1;
  bit          m_stop = 0;
  int unsigned m_k = 0;
  int unsigned m_len = 0;
  int unsigned m_mode = 0;
  logic [DW-1:0] m_seed = '0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_init = 1; m_busy = 0; m_k = 0; m_zero = 1; m_stop = 0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (start_i) begin
          m_busy = 1; m_k = 0; m_zero = 0; m_stop = 0;
          m_mode = int'(mode_i);
          m_len  = int'(burst_len_i);
          m_seed = (mode_i == 2'd2 && seed_i == '0) ? 32'h1 : seed_i;
        end
      end else begin
        if (stop_i) m_stop = 1;
        if (ready_i) begin
          bit fin;
          fin = (m_len != 0 && m_k + 1 == m_len) || m_stop;
          m_k++;
          if (fin) m_busy = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted beats.
  logic [DW-1:0] log_data[$];
  bit            log_last[$];

  always @(negedge clk) begin
    if (m_init) begin
      chk("valid", valid_o, m_busy);
      chk("busy", busy_o, m_busy);
      chk("beats", beats_o, LW'(m_k));
      chk("last", last_o, m_busy && m_len != 0 && m_k + 1 == m_len);
      if (m_busy) chk("data", data_o, data_at(m_mode, m_seed, m_k));
      else if (m_zero) chk("data_rst", data_o, 0);
      if (valid_o && ready_i) begin
        log_data.push_back(data_o);
        log_last.push_back(last_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_burst(input logic [1:0] mode, input logic [DW-1:0] seed,
                             input logic [LW-1:0] len);
    log_data.delete();
    log_last.delete();
    start_i = 1; mode_i = mode; seed_i = seed; burst_len_i = len;
    tick();
    start_i = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    chk(name, busy_o, 0);
  endtask

  task automatic wait_beats(input string name, input int unsigned target);
    int n = 0;
    while (beats_o != LW'(target) && n < 200) begin
      tick();
      n++;
    end
    chk(name, beats_o, target);
  endtask

  initial begin
    // Reset for two cycles with start_i held high: must be ignored.
    start_i = 1;
    tick();
    tick();
    rst_i = 0;
    start_i = 0;
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_beats", beats_o, 0);

    // Counting burst wrapping through zero.
    ready_i = 1;
    start_burst(2'd1, 32'hFFFF_FFFE, 16'd4);
    wait_idle("count_timeout");
    chk("count_n", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("count_d0", log_data[0], 32'hFFFF_FFFE);
      chk("count_d1", log_data[1], 32'hFFFF_FFFF);
      chk("count_d2", log_data[2], 32'h0);
      chk("count_d3", log_data[3], 32'h1);
      chk("count_l2", log_last[2], 0);
      chk("count_l3", log_last[3], 1);
    end
    chk("count_beats", beats_o, 4);

    // Constant burst under alternating backpressure.
    ready_i = 0;
    start_burst(2'd0, 32'hA5, 16'd3);
    for (int i = 0; i < 40 && busy_o; i++) begin
      ready_i = ~ready_i;
      tick();
    end
    chk("bp_idle", busy_o, 0);
    chk("bp_n", log_data.size(), 3);
    if (log_data.size() == 3) begin
      chk("bp_d2", log_data[2], 32'hA5);
      chk("bp_l1", log_last[1], 0);
      chk("bp_l2", log_last[2], 1);
    end
    chk("bp_beats", beats_o, 3);

    // LFSR with zero seed, then an immediate single-beat burst.
    ready_i = 1;
    start_burst(2'd2, 32'h0, 16'd2);
    wait_idle("lfsr_timeout");
    chk("lfsr_n", log_data.size(), 2);
    if (log_data.size() == 2) begin
      chk("lfsr_d0", log_data[0], 32'h1);
      chk("lfsr_d1", log_data[1], 32'h8020_0003);
      chk("lfsr_l1", log_last[1], 1);
    end
    start_burst(2'd2, 32'h0, 16'd1);
    wait_idle("one_timeout");
    chk("one_n", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("one_d0", log_data[0], 32'h1);
      chk("one_l0", log_last[0], 1);
    end

    // stop_i while idle does nothing.
    stop_i = 1;
    tick();
    stop_i = 0;
    tick();
    chk("idle_stop", busy_o, 0);

    // Unbounded burst (reserved mode acts as constant) ended by a stop on a stalled beat.
    start_burst(2'd3, 32'h5A, 16'd0);
    wait_beats("stop_reach5", 5);
    ready_i = 0;
    stop_i = 1;
    tick();
    stop_i = 0;
    tick();
    tick();
    chk("stop_held", valid_o, 1);
    ready_i = 1;
    wait_idle("stop_timeout");
    chk("stop_beats", beats_o, 6);
    chk("stop_n", log_data.size(), 6);
    for (int i = 0; i < log_last.size(); i++) chk("stop_nolast", log_last[i], 0);

    // Reset in the middle of a bounded burst, then a fresh full burst.
    start_burst(2'd1, 32'h10, 16'd8);
    wait_beats("mid_reach2", 2);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("mid_valid", valid_o, 0);
    chk("mid_beats", beats_o, 0);
    start_burst(2'd1, 32'h10, 16'd8);
    wait_idle("post_timeout");
    chk("post_n", log_data.size(), 8);
    if (log_data.size() == 8) begin
      chk("post_d7", log_data[7], 32'h17);
      chk("post_l7", log_last[7], 1);
    end
    chk("post_beats", beats_o, 8);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
